ram_ctrl_74189: RTL
===================

RAM_CTRL_74189 -- requirements
Module: ram_ctrl_74189

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low; ports named clk and rst_n.
REQ-002 Parameter WE_CYCLES, default 1, range 1..15: write-enable low pulse width in clk cycles.
REQ-003 Ports SHALL be:
  clk        in   1  clock, rising edge
  rst_n      in   1  synchronous active-low reset
  prg_req    in   1  loader request, held until prg_ack
  prg_we     in   1  loader write(1)/read(0)
  prg_addr   in   4  loader address
  prg_wdata  in   8  loader write data
  prg_ack    out  1  one-cycle completion pulse
  prg_rdata  out  8  loader read data, valid with prg_ack
  cpu_req / cpu_we / cpu_addr / cpu_wdata / cpu_ack / cpu_rdata: same as prg_*, CPU port
  ram_cs_n   out  1  chip select to both 74189s, active-low
  ram_we_n   out  1  write enable, active-low
  ram_a      out  4  RAM address
  ram_d      out  8  RAM data in (high nibble chip 1, low nibble chip 0)
  ram_o      in   8  RAM outputs, inverted data, Z when deselected
  busy       out  1  high in every state except IDLE
  err        out  1  write-verify mismatch pulse, valid with ack

Function
REQ-004 FSM states: IDLE, SETUP, WPULSE, HOLD, VERIFY, SAMPLE, DONE.
REQ-005 IDLE: ram_cs_n=1, ram_we_n=1; on any req, latch winner's we/addr/wdata, go SETUP.
REQ-006 Arbitration only in IDLE; fixed priority prg over cpu; no preemption; both requests same cycle -> prg served, cpu waits.
REQ-007 SETUP (1 cycle): ram_cs_n=0, ram_we_n=1, ram_a/ram_d driven from latch; write -> WPULSE, read -> SAMPLE.
REQ-008 WPULSE: ram_we_n=0 for exactly WE_CYCLES cycles (4-bit counter), ram_a/ram_d stable, then HOLD.
REQ-009 HOLD (1 cycle): ram_we_n=1, ram_cs_n=0, address/data stable; then VERIFY if enabled, else DONE.
REQ-010 SAMPLE (1 cycle): rdata register <= ~ram_o; then DONE.
REQ-011 DONE (1 cycle): ram_cs_n=1; granted port's ack=1, its rdata valid; other port ack=0; then IDLE.
REQ-012 Latency from req-seen-in-IDLE cycle to ack: read 3 cycles; write 3+WE_CYCLES (4+WE_CYCLES with verify).
REQ-013 Requester SHALL hold req and operands until ack; req still high in IDLE after ack is a new transaction.
REQ-014 rdata of each port holds its last read value until its next read completes; write does not alter rdata.
REQ-015 ram_we_n SHALL never be low while ram_cs_n is high, nor change in the same cycle as ram_a.

Reset
REQ-016 While rst_n=0 at a clk edge: state IDLE, ram_cs_n=1, ram_we_n=1, ram_a=0, ram_d=0, acks 0, rdata 0, busy 0, err 0.
REQ-017 Reset mid-WPULSE SHALL release ram_we_n at that edge; target word content undefined; no ack issued.

Configuration
REQ-018 Macro RAM_CTRL_VERIFY_EN defined: after HOLD, VERIFY state (cs_n=0, we_n=1, 1 cycle) compares ~ram_o to latched wdata; err=1 with ack on mismatch.
REQ-019 Macro undefined: no VERIFY state, HOLD -> DONE, err tied 0.

Structure
REQ-020 Package ram_ctrl_pkg SHALL hold state enum, ADDR_W=4, DATA_W=8, port-select encoding.
REQ-021 Sub-module ram_ctrl_arb SHALL implement the fixed-priority grant (combinational, inputs prg_req/cpu_req, one-hot grant).

Verification
REQ-022 Bench wraps two ram_74189 models; prg write addr 0x0 data 0xA5 -> ram_we_n low exactly 1 cycle, prg_ack at cycle 4, no cpu_ack.
REQ-023 cpu read addr 0x0 after REQ-022 -> cpu_ack at cycle 3, cpu_rdata=0xA5.
REQ-024 prg write 0x3<-0x3C and cpu read 0x3 same cycle -> prg_ack first; cpu_ack later with cpu_rdata=0x3C.
REQ-025 WE_CYCLES=3, write 0xF<-0xFF -> ram_we_n low 3 consecutive cycles, ack at cycle 6; address wraps nothing, 0xF readback 0xFF.
REQ-026 rst_n=0 during WPULSE -> next edge ram_we_n=1, ram_cs_n=1, busy=0, no ack.
REQ-027 RAM_CTRL_VERIFY_EN with model forcing bit 0 stuck -> write 0x01 gives err=1 with ack; write 0x00 gives err=0.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the dual-port 74189 RAM controller.
// The optional write-verify step is enabled by the RAM_CTRL_VERIFY_EN macro.
package ram_ctrl_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    // Controller sequence: VERIFY is only reachable when write-verify is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        WPULSE = 3'd2,
        HOLD   = 3'd3,
        VERIFY = 3'd4,
        SAMPLE = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Which requester owns the transaction currently in flight.
    typedef enum logic {
        PORT_PRG = 1'b0,
        PORT_CPU = 1'b1
    } port_t;

    // One-hot grant encoding produced by the arbiter.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_PRG  = 2'b01;
    localparam logic [1:0] GNT_CPU  = 2'b10;

endpackage

// File: rtl/ram_ctrl_arb.sv
// Fixed-priority arbiter: the loader port always wins over the CPU port.
module ram_ctrl_arb
    import ram_ctrl_pkg::*;
(
    input  logic       prg_req,
    input  logic       cpu_req,
    output logic [1:0] grant
);

    // One-hot grant, loader first; no grant when nobody asks.
    always_comb begin
        grant = GNT_NONE;
        if (prg_req) begin
            grant = GNT_PRG;
        end else if (cpu_req) begin
            grant = GNT_CPU;
        end
    end

endmodule

// File: rtl/ram_ctrl_74189.sv
// Two-port controller for a pair of 74189 16x4 RAMs (high nibble chip 1,
// low nibble chip 0). The chips present inverted data on their outputs,
// so every read is re-inverted before it reaches a requester.
// Optional feature: define RAM_CTRL_VERIFY_EN to add a read-back check
// after every write, reported on err together with the ack.
module ram_ctrl_74189
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned WE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prg_req,
    input  logic              prg_we,
    input  logic [ADDR_W-1:0] prg_addr,
    input  logic [DATA_W-1:0] prg_wdata,
    output logic              prg_ack,
    output logic [DATA_W-1:0] prg_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_o,
    output logic              busy,
    output logic              err
);

    // Write pulse counter reloads to WE_CYCLES-1 and counts down to zero.
    localparam logic [3:0] CNT_INIT = 4'(WE_CYCLES - 1);

    state_t     state;
    port_t      sel;
    logic       we_lat;
    logic [3:0] we_cnt;
    logic [1:0] grant;

    ram_ctrl_arb u_arb (
        .prg_req (prg_req),
        .cpu_req (cpu_req),
        .grant   (grant)
    );

`ifdef RAM_CTRL_VERIFY_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Transaction sequencer; every RAM strobe and handshake is registered so
    // the bus changes only on clock edges. ram_a/ram_d double as the operand
    // latch and stay put until the next grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= PORT_PRG;
            we_lat    <= 1'b0;
            we_cnt    <= '0;
            ram_cs_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_a     <= '0;
            ram_d     <= '0;
            prg_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            prg_rdata <= '0;
            cpu_rdata <= '0;
            busy      <= 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            prg_ack <= 1'b0;
            cpu_ack <= 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
            err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant != GNT_NONE) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        ram_cs_n <= 1'b0;
                        ram_we_n <= 1'b1;
                        if (grant == GNT_PRG) begin
                            sel    <= PORT_PRG;
                            we_lat <= prg_we;
                            ram_a  <= prg_addr;
                            ram_d  <= prg_wdata;
                        end else begin
                            sel    <= PORT_CPU;
                            we_lat <= cpu_we;
                            ram_a  <= cpu_addr;
                            ram_d  <= cpu_wdata;
                        end
                    end
                end
                SETUP: begin
                    if (we_lat) begin
                        state    <= WPULSE;
                        ram_we_n <= 1'b0;
                        we_cnt   <= CNT_INIT;
                    end else begin
                        state <= SAMPLE;
                    end
                end
                WPULSE: begin
                    if (we_cnt == 4'd0) begin
                        state    <= HOLD;
                        ram_we_n <= 1'b1;
                    end else begin
                        we_cnt <= we_cnt - 4'd1;
                    end
                end
                HOLD: begin
`ifdef RAM_CTRL_VERIFY_EN
                    state <= VERIFY;
`else
                    state    <= DONE;
                    ram_cs_n <= 1'b1;
                    if (sel == PORT_PRG) prg_ack <= 1'b1;
                    else                 cpu_ack <= 1'b1;
`endif
                end
`ifdef RAM_CTRL_VERIFY_EN
                VERIFY: begin
                    state    <= DONE;
                    ram_cs_n <= 1'b1;
                    err_q    <= ((~ram_o) != ram_d);
                    if (sel == PORT_PRG) prg_ack <= 1'b1;
                    else                 cpu_ack <= 1'b1;
                end
`endif
                SAMPLE: begin
                    state    <= DONE;
                    ram_cs_n <= 1'b1;
                    if (sel == PORT_PRG) begin
                        prg_rdata <= ~ram_o;
                        prg_ack   <= 1'b1;
                    end else begin
                        cpu_rdata <= ~ram_o;
                        cpu_ack   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ram_cs_n <= 1'b1;
                    ram_we_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
